// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: pointer sizing, read-mode
// constants and parameter sanity helpers used at elaboration time.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // One extra MSB beyond the address bits acts as the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit thresholds_ok(input int depth, input int ae, input int af);
        return (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and a
// selectable standard (registered) or first-word-fall-through read port.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_flags: DATA_W must be at least 1");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two, at least 2");
    end
    if (!thresholds_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_flags: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_accept;
    logic              wr_accept;

    // All status outputs decode from the registered pointers only.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= PW'(AF_THRESH));
    assign almost_empty = (count <= PW'(AE_THRESH));

    // A read never pops an empty FIFO; a write into a full FIFO is allowed
    // only when the same-cycle read frees a slot.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            overflow  <= (overflow  && !clr_err) || (wr_en && !wr_accept);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is presented while non-empty; zero otherwise so the
        // unreset array never leaks onto rd_data.
        assign rd_data  = empty ? '0 : mem_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept) begin
                    rd_data <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share stimulus and are
// compared against a queue-based reference model with a read-data scoreboard.
module tb_sync_fifo_flags;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;

    logic [DATA_W-1:0] s_rd_data, f_rd_data;
    logic              s_rd_valid, f_rd_valid;
    logic              s_full, f_full, s_empty, f_empty;
    logic              s_af, f_af, s_ae, f_ae;
    logic [CW-1:0]     s_count, f_count;
    logic              s_ovf, f_ovf, s_unf, f_unf;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Reference model: contents as a queue, sticky flags as bits.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                m_ovf = 1'b0;
    bit                m_unf = 1'b0;
    bit                m_valid = 1'b0;
    logic [DATA_W-1:0] last_data = '0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_flags #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dut_fw (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: flags against the model every cycle; standard-port read data
    // is popped from the scoreboard whenever rd_valid is presented.
    always @(negedge clk) begin
        int n;
        if (mon_en && !rst) begin
            n = model_q.size();
            check("count", 32'(s_count), n);
            check("fw_count", 32'(f_count), n);
            check("full", 32'(s_full), 32'(n == DEPTH));
            check("empty", 32'(s_empty), 32'(n == 0));
            check("almost_full", 32'(s_af), 32'(n >= AF));
            check("almost_empty", 32'(s_ae), 32'(n <= AE));
            check("fw_full", 32'(f_full), 32'(n == DEPTH));
            check("fw_empty", 32'(f_empty), 32'(n == 0));
            check("overflow", 32'(s_ovf), 32'(m_ovf));
            check("underflow", 32'(s_unf), 32'(m_unf));
            check("fw_overflow", 32'(f_ovf), 32'(m_ovf));
            check("fw_underflow", 32'(f_unf), 32'(m_unf));
            check("std_valid", 32'(s_rd_valid), 32'(m_valid));
            if (s_rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("std_unexpected_word", 32'(1), 32'(0));
                end else begin
                    last_data = exp_q.pop_front();
                    check("std_data", 32'(s_rd_data), 32'(last_data));
                end
            end else begin
                check("std_hold", 32'(s_rd_data), 32'(last_data));
            end
            check("fw_valid", 32'(f_rd_valid), 32'(n != 0));
            if (n != 0) begin
                check("fw_data", 32'(f_rd_data), 32'(model_q[0]));
            end
        end
    end

    // Driver: apply one cycle of stimulus, then advance the model just after
    // the edge using the pre-edge occupancy.
    task automatic cycle(input bit w, input bit r, input logic [DATA_W-1:0] d, input bit c);
        int n;
        bit ra;
        bit wa;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        clr_err = c;
        n  = model_q.size();
        ra = r && (n > 0);
        wa = w && ((n < DEPTH) || ra);
        @(posedge clk);
        #1;
        m_valid = ra;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && !wa) m_ovf = 1'b1;
        if (r && (n == 0)) m_unf = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        #1;
        check("rst_count", 32'(s_count), 32'(0));
        check("rst_empty", 32'(s_empty), 32'(1));
        check("rst_full", 32'(s_full), 32'(0));
        check("rst_almost_empty", 32'(s_ae), 32'(1));
        check("rst_almost_full", 32'(s_af), 32'(0));
        check("rst_rd_valid", 32'(s_rd_valid), 32'(0));
        check("rst_rd_data", 32'(s_rd_data), 32'(0));
        check("rst_overflow", 32'(s_ovf), 32'(0));
        check("rst_underflow", 32'(s_unf), 32'(0));
        check("rst_fw_count", 32'(f_count), 32'(0));
        check("rst_fw_valid", 32'(f_rd_valid), 32'(0));
        check("rst_fw_data", 32'(f_rd_data), 32'(0));
        model_q.delete();
        exp_q.delete();
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_valid   = 1'b0;
        last_data = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();

        // Fill to full, then one write too many.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DATA_W'(i), 1'b0);
        check("full_after_16", 32'(s_full), 32'(1));
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        check("overflow_17th", 32'(s_ovf), 32'(1));
        check("count_17th", 32'(s_count), 32'(DEPTH));

        // Clear, then simultaneous write/read while full.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h20, 1'b0);
        check("sim_full_no_ovf", 32'(s_ovf), 32'(0));

        // Drain, then read while empty.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("underflow_empty_read", 32'(s_unf), 32'(1));

        // Simultaneous write/read at count 0.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h33, 1'b0);
        check("sim_empty_unf", 32'(s_unf), 32'(1));
        check("sim_empty_count", 32'(s_count), 32'(1));

        // Simultaneous write/read at count 5.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'h44, 1'b1);
        check("sim_mid_count", 32'(s_count), 32'(5));

        // FWFT visibility of a single word with no read request.
        do_reset();
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        check("fwft_data", 32'(f_rd_data), 32'(8'hA5));
        check("fwft_valid", 32'(f_rd_valid), 32'(1));
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_empty_after_pop", 32'(f_empty), 32'(1));

        // Wrap-around: hold occupancy at 8 while 40 words stream through.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, DATA_W'($urandom), 1'b0);

        // Randomized traffic with drifting bias and a reset mid-burst.
        for (int i = 0; i < 400; i++) begin
            int wb;
            wb = ((i / 50) % 2 == 0) ? 75 : 25;
            if (i == 230) do_reset();
            cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) >= wb - 10,
                  DATA_W'($urandom), $urandom_range(0, 15) == 0);
        end

        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
